// File: rtl/icache_fetch.sv
// Direct-mapped read-only instruction cache with byte-wide refill and straddle support.
// Define ICACHE_STATS_EN to add saturating hit_cnt / miss_cnt outputs.
module icache_fetch #(
  parameter int LINE_BYTES = 16,
  parameter int LINE_NUM   = 32,
  parameter int ADDR_BIT   = 17
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        inst_req,
  input  logic [31:0] pc,
  input  logic        clear,
  output logic        inst_ready,
  output logic [31:0] inst,
  output logic        mem_busy,
  output logic        ram_req,
  input  logic        ram_grant,
  output logic [31:0] ram_addr,
  input  logic [7:0]  ram_din
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt
`endif
);

  localparam int OFF_W  = $clog2(LINE_BYTES);
  localparam int IDX_W  = $clog2(LINE_NUM);
  localparam int TAG_LO = OFF_W + IDX_W;
  localparam int TAG_W  = ADDR_BIT - TAG_LO;
  localparam int CNT_W  = OFF_W + 1;
  localparam logic [CNT_W-1:0] FULL     = CNT_W'(LINE_BYTES);
  localparam logic [OFF_W-1:0] LAST_OFF = OFF_W'(LINE_BYTES - 2);

  typedef enum logic {IDLE, REFILL} state_e;

  state_e                      state_q, state_d;
  logic [CNT_W-1:0]            iss_q, iss_d;
  logic [CNT_W-1:0]            rcv_q, rcv_d, rcv_nxt;
  logic [31:0]                 base_q, base_d;
  logic                        pend_q, pend_d;
  logic [LINE_NUM-1:0]         valid_q;
  logic [TAG_W-1:0]            tag_q  [LINE_NUM];
  logic [LINE_BYTES-1:0][7:0]  data_q [LINE_NUM];

  logic                        start, install, wr_en;

  // Lookup: line A holds pc, line B is the following line (used for straddles)
  logic [31:0]      pc_b, base_a, base_b;
  logic [IDX_W-1:0] idx_a, idx_b, fill_idx, start_idx;
  logic [TAG_W-1:0] tag_a, tag_b, fill_tag;
  logic [OFF_W-1:0] off, off1, off2, off3;
  logic             hit_a, hit_b, need_b;
  logic             unused_bits;

  assign pc_b   = pc + 32'(LINE_BYTES);
  assign idx_a  = pc[TAG_LO-1:OFF_W];
  assign tag_a  = pc[ADDR_BIT-1:TAG_LO];
  assign idx_b  = pc_b[TAG_LO-1:OFF_W];
  assign tag_b  = pc_b[ADDR_BIT-1:TAG_LO];
  assign base_a = {pc[31:OFF_W], {OFF_W{1'b0}}};
  assign base_b = {pc_b[31:OFF_W], {OFF_W{1'b0}}};
  assign off    = {pc[OFF_W-1:1], 1'b0};
  assign off1   = off + OFF_W'(1);
  assign off2   = off + OFF_W'(2);
  assign off3   = off + OFF_W'(3);
  assign unused_bits = ^{pc[31:ADDR_BIT], pc[0], pc_b[31:ADDR_BIT], pc_b[OFF_W-1:0]};

  assign hit_a = valid_q[idx_a] && (tag_q[idx_a] == tag_a);
  assign hit_b = valid_q[idx_b] && (tag_q[idx_b] == tag_b);

  always_comb begin
    inst = {data_q[idx_a][off3], data_q[idx_a][off2], data_q[idx_a][off1], data_q[idx_a][off]};
    if (off == LAST_OFF) inst[31:16] = {data_q[idx_b][1], data_q[idx_b][0]};
  end

  // Only a 32-bit instruction sitting in the last halfword needs line B
  assign need_b     = (off == LAST_OFF) && (inst[1:0] == 2'b11);
  assign inst_ready = inst_req && rdy_in && !clear && hit_a && (!need_b || hit_b);

  assign fill_idx  = base_q[TAG_LO-1:OFF_W];
  assign fill_tag  = base_q[ADDR_BIT-1:TAG_LO];
  assign start_idx = base_d[TAG_LO-1:OFF_W];

  always_comb begin
    state_d = state_q;
    iss_d   = iss_q;
    rcv_d   = rcv_q;
    rcv_nxt = rcv_q;
    base_d  = base_q;
    pend_d  = 1'b0;
    start   = 1'b0;
    install = 1'b0;
    ram_req = 1'b0;
    case (state_q)
      IDLE: begin
        if (rdy_in && inst_req && !clear && !inst_ready) begin
          state_d = REFILL;
          start   = 1'b1;
          base_d  = hit_a ? base_b : base_a;
          iss_d   = '0;
          rcv_d   = '0;
        end
      end
      REFILL: begin
        if (!rdy_in) begin
          // the byte for an address consumed just before the pause still arrives
          if (pend_q) rcv_d = rcv_q + CNT_W'(1);
        end else if (clear) begin
          state_d = IDLE;
        end else begin
          ram_req = (iss_q < FULL);
          if (ram_req && ram_grant) begin
            iss_d  = iss_q + CNT_W'(1);
            pend_d = 1'b1;
          end
          rcv_nxt = rcv_q + CNT_W'(pend_q);
          rcv_d   = rcv_nxt;
          if (rcv_nxt == FULL) begin
            install = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign wr_en    = (state_q == REFILL) && pend_q && !(rdy_in && clear);
  assign mem_busy = (state_q == REFILL);
  assign ram_addr = (state_q == REFILL) ? base_q + 32'(iss_q) : 32'h0;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q <= IDLE;
      iss_q   <= '0;
      rcv_q   <= '0;
      base_q  <= '0;
      pend_q  <= 1'b0;
      valid_q <= '0;
    end else begin
      state_q <= state_d;
      iss_q   <= iss_d;
      rcv_q   <= rcv_d;
      base_q  <= base_d;
      pend_q  <= pend_d;
      // the victim line is invalidated up front so a partial fill is never visible
      if (start)   valid_q[start_idx] <= 1'b0;
      if (install) valid_q[fill_idx]  <= 1'b1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (wr_en)   data_q[fill_idx][rcv_q[OFF_W-1:0]] <= ram_din;
    if (install) tag_q[fill_idx] <= fill_tag;
  end

`ifdef ICACHE_STATS_EN
  logic [31:0] hit_q, miss_q;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      hit_q  <= '0;
      miss_q <= '0;
    end else begin
      if (inst_ready && hit_q != 32'hFFFF_FFFF) hit_q  <= hit_q + 32'd1;
      if (start && miss_q != 32'hFFFF_FFFF)     miss_q <= miss_q + 32'd1;
    end
  end

  assign hit_cnt  = hit_q;
  assign miss_cnt = miss_q;
`endif

endmodule

// File: tb/tb_icache_fetch.sv
// Directed bench for icache_fetch: byte RAM model behind an arbiter, hand-computed expectations.
module tb_icache_fetch;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, inst_req, clear, ram_grant;
  logic [31:0] pc;
  logic        inst_ready, mem_busy, ram_req;
  logic [31:0] inst, ram_addr;
  logic [7:0]  ram_din;

  logic [7:0]  mem [0:4095];
  logic        gnt_tog = 1'b0;
  int          total = 0;
  int          bad = 0;
  int          r;
  logic [31:0] fa;

  icache_fetch dut (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .rdy_in     (rdy_in),
    .inst_req   (inst_req),
    .pc         (pc),
    .clear      (clear),
    .inst_ready (inst_ready),
    .inst       (inst),
    .mem_busy   (mem_busy),
    .ram_req    (ram_req),
    .ram_grant  (ram_grant),
    .ram_addr   (ram_addr),
    .ram_din    (ram_din)
  );

  always #5 clk_in = ~clk_in;

  // RAM: data appears the cycle after the address is consumed
  always @(posedge clk_in)
    if (ram_req && ram_grant) ram_din <= mem[ram_addr[11:0]];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic cyc;
    @(posedge clk_in);
    #1;
    if (gnt_tog) ram_grant = ~ram_grant;
  endtask

  function automatic logic [31:0] word(input logic [11:0] a);
    return {mem[a+12'd3], mem[a+12'd2], mem[a+12'd1], mem[a]};
  endfunction

  task automatic run_fetch(input logic [31:0] a, output int refills, output logic [31:0] first_addr);
    logic prev;
    refills    = 0;
    first_addr = 32'hFFFF_FFFF;
    prev       = mem_busy;
    pc         = a;
    inst_req   = 1'b1;
    for (int n = 0; n < 200; n++) begin
      #1;
      if (inst_ready) break;
      if (mem_busy && !prev) refills++;
      prev = mem_busy;
      if (ram_req && first_addr == 32'hFFFF_FFFF) first_addr = ram_addr;
      cyc();
    end
    chk("fetch_ready", {31'b0, inst_ready}, 32'd1);
  endtask

  task automatic check_line(input logic [31:0] base, input string tag);
    for (int w = 0; w < 4; w++) begin
      pc       = base + 32'(4 * w);
      inst_req = 1'b1;
      #1;
      chk({tag, "_rdy"}, {31'b0, inst_ready}, 32'd1);
      chk(tag, inst, word(pc[11:0]));
      cyc();
    end
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 8'(i * 37 + 5);
    mem[0] = 8'h93; mem[1] = 8'h00; mem[2] = 8'h10; mem[3] = 8'h00;
    mem[6] = 8'h05; mem[7] = 8'h45;
    mem[12'h00E] = 8'h17; mem[12'h00F] = 8'h05; mem[12'h010] = 8'h33; mem[12'h011] = 8'h22;
    mem[12'h1FE] = 8'h03; mem[12'h1FF] = 8'h12; mem[12'h200] = 8'hAB; mem[12'h201] = 8'hCD;

    rst_in = 1'b1; rdy_in = 1'b1; inst_req = 1'b0; clear = 1'b0; ram_grant = 1'b1; pc = 32'h0;
    #1;
    chk("rst_ready", {31'b0, inst_ready}, 32'd0);
    chk("rst_busy",  {31'b0, mem_busy},   32'd0);
    chk("rst_req",   {31'b0, ram_req},    32'd0);
    chk("rst_addr",  ram_addr,            32'd0);
    @(posedge clk_in); @(posedge clk_in); #1;
    rst_in = 1'b0;
    cyc();

    // cold miss on line 0
    pc = 32'h0; inst_req = 1'b1;
    #1;
    chk("cold_miss", {31'b0, inst_ready}, 32'd0);
    cyc();
    for (int k = 0; k < 17; k++) begin
      chk("cold_busy", {31'b0, mem_busy}, 32'd1);
      if (k < 16) begin
        chk("cold_req",  {31'b0, ram_req}, 32'd1);
        chk("cold_addr", ram_addr, 32'(k));
      end else begin
        chk("cold_req_end", {31'b0, ram_req}, 32'd0);
      end
      cyc();
    end
    chk("cold_idle",  {31'b0, mem_busy},   32'd0);
    chk("cold_ready", {31'b0, inst_ready}, 32'd1);
    chk("cold_inst",  inst,                32'h0010_0093);

    // compressed halfwords inside line 0
    pc = 32'h2; #1;
    chk("c2_ready", {31'b0, inst_ready}, 32'd1);
    chk("c2_inst",  {16'h0, inst[15:0]}, 32'h0000_0010);
    pc = 32'h6; #1;
    chk("c6_ready", {31'b0, inst_ready}, 32'd1);
    chk("c6_inst",  {16'h0, inst[15:0]}, 32'h0000_4505);
    cyc();
    chk("c6_norefill", {31'b0, mem_busy}, 32'd0);

    // 32-bit straddle into invalid line 0x10
    pc = 32'hE; #1;
    chk("strad_miss", {31'b0, inst_ready}, 32'd0);
    run_fetch(32'hE, r, fa);
    chk("strad_refills", 32'(r), 32'd1);
    chk("strad_base",    fa,     32'h10);
    chk("strad_inst",    inst,   32'h2233_0517);
    inst_req = 1'b0;
    cyc();

    // grant toggling each cycle
    gnt_tog = 1'b1;
    run_fetch(32'h40, r, fa);
    chk("tog_refills", 32'(r), 32'd1);
    gnt_tog = 1'b0; ram_grant = 1'b1;
    check_line(32'h40, "tog_line");

    // flush five cycles into a refill
    inst_req = 1'b0; cyc();
    pc = 32'h80; inst_req = 1'b1;
    cyc();
    repeat (4) cyc();
    chk("clr_busy", {31'b0, mem_busy}, 32'd1);
    clear = 1'b1; inst_req = 1'b0;
    cyc();
    clear = 1'b0;
    chk("clr_req",  {31'b0, ram_req},  32'd0);
    chk("clr_idle", {31'b0, mem_busy}, 32'd0);
    cyc();
    pc = 32'h80; inst_req = 1'b1; #1;
    chk("clr_remiss", {31'b0, inst_ready}, 32'd0);
    run_fetch(32'h80, r, fa);
    chk("clr_refills", 32'(r), 32'd1);
    chk("clr_base",    fa,     32'h80);
    check_line(32'h80, "clr_line");

    // flushed refill into index 4 must leave the old 0x40 line invalid
    inst_req = 1'b0; cyc();
    pc = 32'h240; inst_req = 1'b1;
    cyc(); cyc(); cyc();
    clear = 1'b1; inst_req = 1'b0;
    cyc();
    clear = 1'b0;
    pc = 32'h40; inst_req = 1'b1; #1;
    chk("victim_inval", {31'b0, inst_ready}, 32'd0);
    inst_req = 1'b0;
    cyc();

    // pause with rdy_in low mid-refill
    pc = 32'hC0; inst_req = 1'b1;
    cyc(); cyc(); cyc();
    rdy_in = 1'b0; #1;
    chk("rdy_req0", {31'b0, ram_req}, 32'd0);
    cyc();
    chk("rdy_hold", {31'b0, mem_busy}, 32'd1);
    chk("rdy_req1", {31'b0, ram_req},  32'd0);
    chk("rdy_addr", ram_addr,          32'hC2);
    rdy_in = 1'b1;
    run_fetch(32'hC0, r, fa);
    check_line(32'hC0, "rdy_line");

    // async reset mid-refill
    inst_req = 1'b0; cyc();
    pc = 32'h100; inst_req = 1'b1;
    cyc(); cyc(); cyc();
    #2;
    rst_in = 1'b1;
    #1;
    chk("arst_busy",  {31'b0, mem_busy},   32'd0);
    chk("arst_req",   {31'b0, ram_req},    32'd0);
    chk("arst_addr",  ram_addr,            32'd0);
    chk("arst_ready", {31'b0, inst_ready}, 32'd0);
    inst_req = 1'b0;
    cyc();
    rst_in = 1'b0;
    cyc();
    pc = 32'h0; inst_req = 1'b1; #1;
    chk("arst_remiss", {31'b0, inst_ready}, 32'd0);
    run_fetch(32'h0, r, fa);
    chk("arst_refills", 32'(r), 32'd1);
    chk("arst_inst",    inst,   32'h0010_0093);

    // straddle across the index wrap, both lines missing
    inst_req = 1'b0; cyc();
    run_fetch(32'h1FE, r, fa);
    chk("wrap_refills", 32'(r), 32'd2);
    chk("wrap_base",    fa,     32'h1F0);
    chk("wrap_inst",    inst,   32'hCDAB_1203);
    inst_req = 1'b0;
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
